// File: rtl/conv_tile_address_gen.sv
// =============================================================================
// Module   : conv_tile_address_gen
// Purpose  : KxK window address sequencer for one image tile, all filters.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module conv_tile_address_gen #(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int TILE_DIM  = 32,
    parameter int KERNEL    = 3,
    parameter int FILT_W    = 8,
    parameter int B_W       = 9,
    parameter int BIAS_BASE = 0,
    parameter int ADDR_W    = $clog2(IMG_W * IMG_H),
    parameter int TSEL_W    = (IMG_W / TILE_DIM > 1) ? $clog2(IMG_W / TILE_DIM) : 1
) (
    input  logic              clock_i,
    input  logic              clear_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              en_i,
    input  logic [TSEL_W-1:0] tile_x_i,
    input  logic [TSEL_W-1:0] tile_y_i,
    input  logic [FILT_W:0]   num_filters_i,
    input  logic              addr_ready_i,
    output logic              addr_valid_o,
    output logic [ADDR_W-1:0] input_address_o,
    output logic              input_pad_o,
    output logic              window_last_o,
    output logic [FILT_W-1:0] filter_address_o,
    output logic              b_element_requested_o,
    output logic [B_W-1:0]    b_element_address_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW   = ADDR_W + 1;
    localparam int RC_W = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
    localparam int K_W  = (KERNEL > 1) ? $clog2(KERNEL) : 1;

    localparam logic [RC_W-1:0] RC_LAST    = RC_W'(TILE_DIM - 1);
    localparam logic [K_W-1:0]  K_LAST     = K_W'(KERNEL - 1);
    localparam logic [B_W-1:0]  BIAS_BASE_V = B_W'(BIAS_BASE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FILT_W-1:0] f_q, f_d;
    logic [RC_W-1:0]   r_q, r_d, c_q, c_d;
    logic [K_W-1:0]    kr_q, kr_d, kc_q, kc_d;
    logic [TSEL_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [FILT_W:0]   nf_q, nf_d;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pad_q, pad_d;
    logic              wlast_q, wlast_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic              breq_q, breq_d;
    logic [B_W-1:0]    baddr_q, baddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_kc, last_kr, last_c, last_r, last_f, last_beat;
    logic [CW-1:0]     x_coord, y_coord, lin_addr;
    logic              in_img;

    assign last_kc   = (kc_q == K_LAST);
    assign last_kr   = (kr_q == K_LAST);
    assign last_c    = (c_q == RC_LAST);
    assign last_r    = (r_q == RC_LAST);
    assign last_f    = (({1'b0, f_q} + 1'b1) == nf_q);
    assign last_beat = last_kc && last_kr && last_c && last_r && last_f;

    // Beat counters: kc fastest, then kr, c, r, filter outermost.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        nf_d    = nf_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tx_d = tile_x_i;
                    ty_d = tile_y_i;
                    nf_d = num_filters_i;
                    f_d  = '0;
                    r_d  = '0;
                    c_d  = '0;
                    kr_d = '0;
                    kc_d = '0;
                    if (num_filters_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (valid_q && addr_ready_i) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else if (!last_kc) begin
                        kc_d = kc_q + 1'b1;
                    end else begin
                        kc_d = '0;
                        if (!last_kr) begin
                            kr_d = kr_q + 1'b1;
                        end else begin
                            kr_d = '0;
                            if (!last_c) begin
                                c_d = c_q + 1'b1;
                            end else begin
                                c_d = '0;
                                if (!last_r) begin
                                    r_d = r_q + 1'b1;
                                end else begin
                                    r_d = '0;
                                    f_d = f_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output image is derived from the next-beat counters so the registered
    // outputs line up with the counter state and hold steady while stalled.
    always_comb begin
        y_coord  = CW'(ty_d) * CW'(TILE_DIM) + CW'(r_d) + CW'(kr_d);
        x_coord  = CW'(tx_d) * CW'(TILE_DIM) + CW'(c_d) + CW'(kc_d);
        in_img   = (x_coord < CW'(IMG_W)) && (y_coord < CW'(IMG_H));
        lin_addr = y_coord * CW'(IMG_W) + x_coord;

        addr_d  = (valid_d && in_img) ? lin_addr[ADDR_W-1:0] : '0;
        pad_d   = valid_d && !in_img;
        wlast_d = valid_d && (kr_d == K_LAST) && (kc_d == K_LAST);
        filt_d  = valid_d ? f_d : '0;
        breq_d  = valid_d && (r_d == '0) && (c_d == '0) && (kr_d == '0) && (kc_d == '0);
        baddr_d = valid_d ? (BIAS_BASE_V + B_W'(f_d)) : '0;
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clock_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            nf_q    <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            pad_q   <= 1'b0;
            wlast_q <= 1'b0;
            filt_q  <= '0;
            breq_q  <= 1'b0;
            baddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            nf_q    <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            pad_q   <= 1'b0;
            wlast_q <= 1'b0;
            filt_q  <= '0;
            breq_q  <= 1'b0;
            baddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en_i) begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            nf_q    <= nf_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            pad_q   <= pad_d;
            wlast_q <= wlast_d;
            filt_q  <= filt_d;
            breq_q  <= breq_d;
            baddr_q <= baddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_valid_o          = valid_q;
    assign input_address_o       = addr_q;
    assign input_pad_o           = pad_q;
    assign window_last_o         = wlast_q;
    assign filter_address_o      = filt_q;
    assign b_element_requested_o = breq_q;
    assign b_element_address_o   = baddr_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;

endmodule

`default_nettype wire
